// File: rtl/dap_swd_pkg.sv
// Shared definitions for the SWD transfer controller: sequence-engine command
// fields, SWD ACK codes, controller FSM states and bit-order helpers.
package dap_swd_pkg;

    localparam logic [3:0] SEQ_CMD_SWD_SEQ = 4'h4;

    localparam int CMD_OP_LSB = 12;
    localparam int CMD_T_BIT  = 7;
    localparam int CMD_CNT_W  = 7;

    localparam logic [2:0] ACK_OK        = 3'b001;
    localparam logic [2:0] ACK_WAIT      = 3'b010;
    localparam logic [2:0] ACK_FAULT     = 3'b100;
    localparam logic [2:0] ACK_PROTO_ERR = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE, ST_REQ, ST_ACK, ST_RDATA, ST_RTURN,
        ST_ATURN, ST_WTURN, ST_WDATA, ST_DONE
    } swd_state_e;

    typedef struct packed {
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } xfer_req_t;

    function automatic logic [15:0] seq_cmd(input logic swdio_t, input logic [CMD_CNT_W-1:0] cnt);
        logic [15:0] cmd;
        cmd                    = '0;
        cmd[15:CMD_OP_LSB]     = SEQ_CMD_SWD_SEQ;
        cmd[CMD_T_BIT]         = swdio_t;
        cmd[CMD_CNT_W-1:0]     = cnt;
        return cmd;
    endfunction

    // The engine shifts MSB first while SWD puts bit 0 on the wire first.
    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/dap_swd_xfer_ctrl_link.sv
// Single-outstanding command link to the sequence engine: holds seq_tx_valid
// until the completion edge, then enforces a quiet gap before the next command.
module dap_seq_link
    import dap_swd_pkg::*;
#(
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue,
    input  logic [15:0] cmd,
    input  logic [63:0] data,
    output logic        done,
    output logic        busy,
    output logic        seq_tx_valid,
    output logic [15:0] seq_tx_cmd,
    output logic [63:0] seq_tx_data,
    input  logic        seq_rx_valid
);

    localparam int GW = $clog2(GAP_CYCLES + 2);

    logic          rx_prev;
    logic [GW-1:0] gap_cnt;

    // The engine holds seq_rx_valid for several cycles; only its rising edge completes a command.
    assign done = seq_tx_valid && seq_rx_valid && !rx_prev;
    assign busy = seq_tx_valid || (gap_cnt != '0);

    // NOTE: reset is sampled on clk, so seq_tx_valid drops at the first edge that sees resetn low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_prev      <= 1'b0;
            gap_cnt      <= '0;
            seq_tx_valid <= 1'b0;
            seq_tx_cmd   <= '0;
            seq_tx_data  <= '0;
        end else begin
            rx_prev <= seq_rx_valid;
            if (issue && !busy) begin
                seq_tx_valid <= 1'b1;
                seq_tx_cmd   <= cmd;
                seq_tx_data  <= data;
            end else if (done) begin
                seq_tx_valid <= 1'b0;
                gap_cnt      <= GW'(GAP_CYCLES);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dap_swd_xfer_ctrl.sv
// Sequences one SWD transfer (request, turnaround, ACK, data, parity) as a chain
// of SWD_SEQ commands, with WAIT retry and read parity checking.
module dap_swd_xfer_ctrl
    import dap_swd_pkg::*;
#(
    parameter int          TURN       = 1,
    parameter logic [15:0] RETRY_MAX  = 16'd255,
    parameter int          GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        xfer_req_valid,
    output logic        xfer_req_ready,
    input  logic        xfer_apndp,
    input  logic        xfer_rnw,
    input  logic [1:0]  xfer_addr,
    input  logic [31:0] xfer_wdata,
    output logic        xfer_rsp_valid,
    output logic [2:0]  xfer_rsp_ack,
    output logic [31:0] xfer_rsp_rdata,
    output logic        xfer_rsp_perr,
    output logic        seq_tx_valid,
    output logic [15:0] seq_tx_cmd,
    output logic [63:0] seq_tx_data,
    input  logic        seq_rx_valid,
    input  logic [15:0] seq_rx_flag,
    input  logic [63:0] seq_rx_data
);

    swd_state_e           state, state_next;
    xfer_req_t            req_q;
    logic [15:0]          retries;
    logic [2:0]           work_ack;
    logic [31:0]          work_rdata;
    logic                 work_perr;
    logic                 issue, cmd_t;
    logic [CMD_CNT_W-1:0] cmd_cnt;
    logic [63:0]          cmd_data;
    logic                 link_done, link_busy;
    logic                 flag_bad, retry_ok, req_par;
    logic [2:0]           ack_rx;
    logic [31:0]          rx_rdata;
    logic                 unused_bits;

    assign xfer_req_ready = (state == ST_IDLE);
    assign req_par        = ^{req_q.apndp, req_q.rnw, req_q.addr};
    assign ack_rx         = {seq_rx_data[0], seq_rx_data[1], seq_rx_data[2]};
    assign rx_rdata       = rev32(seq_rx_data[32:1]);
    assign flag_bad       = (seq_rx_flag[CMD_CNT_W-1:0] != seq_tx_cmd[CMD_CNT_W-1:0]);
    assign retry_ok       = (work_ack == ACK_WAIT) && (retries < RETRY_MAX);
    assign unused_bits    = ^{seq_rx_flag[15:CMD_CNT_W], seq_rx_data[63:33]};

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cmd_t      = 1'b1;
        cmd_cnt    = '0;
        cmd_data   = '0;
        unique case (state)
            ST_IDLE:  if (xfer_req_valid) state_next = ST_REQ;
            ST_REQ: begin
                cmd_t           = 1'b0;
                cmd_cnt         = 7'd8;
                cmd_data[63:56] = {1'b1, req_q.apndp, req_q.rnw, req_q.addr[0],
                                   req_q.addr[1], req_par, 1'b0, 1'b1};
            end
            ST_ACK:   cmd_cnt = CMD_CNT_W'(TURN + 3);
            ST_RDATA: cmd_cnt = 7'd33;
            ST_RTURN, ST_ATURN, ST_WTURN: cmd_cnt = CMD_CNT_W'(TURN);
            ST_WDATA: begin
                cmd_t    = 1'b0;
                cmd_cnt  = 7'd33;
                cmd_data = {rev32(req_q.wdata), ^req_q.wdata, 31'd0};
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        issue = !link_busy && (state != ST_IDLE) && (state != ST_DONE);

        if (link_done) begin
            if (flag_bad) begin
                state_next = ST_DONE;
            end else begin
                unique case (state)
                    ST_REQ:   state_next = ST_ACK;
                    ST_ACK:   state_next = (ack_rx != ACK_OK) ? ST_ATURN :
                                           (req_q.rnw ? ST_RDATA : ST_WTURN);
                    ST_RDATA: state_next = ST_RTURN;
                    ST_WTURN: state_next = ST_WDATA;
                    ST_ATURN: state_next = retry_ok ? ST_REQ : ST_DONE;
                    default:  state_next = ST_DONE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q          <= '0;
            retries        <= '0;
            work_ack       <= '0;
            work_rdata     <= '0;
            work_perr      <= 1'b0;
            xfer_rsp_valid <= 1'b0;
            xfer_rsp_ack   <= '0;
            xfer_rsp_rdata <= '0;
            xfer_rsp_perr  <= 1'b0;
        end else begin
            xfer_rsp_valid <= 1'b0;
            if (state == ST_IDLE && xfer_req_valid) begin
                req_q      <= '{apndp: xfer_apndp, rnw: xfer_rnw, addr: xfer_addr, wdata: xfer_wdata};
                retries    <= '0;
                work_ack   <= '0;
                work_rdata <= '0;
                work_perr  <= 1'b0;
            end
            if (link_done) begin
                if (flag_bad) begin
                    work_ack   <= ACK_PROTO_ERR;
                    work_rdata <= '0;
                    work_perr  <= 1'b0;
                end else if (state == ST_ACK) begin
                    work_ack <= ack_rx;
                end else if (state == ST_RDATA) begin
                    work_rdata <= rx_rdata;
                    work_perr  <= (^rx_rdata) != seq_rx_data[0];
                end else if (state == ST_ATURN && retry_ok) begin
                    retries <= retries + 16'd1;
                end
            end
            // Response fields only change here, so they stay put until the next transfer ends.
            if (state == ST_DONE) begin
                xfer_rsp_valid <= 1'b1;
                xfer_rsp_ack   <= work_ack;
                xfer_rsp_rdata <= work_rdata;
                xfer_rsp_perr  <= work_perr;
            end
        end
    end

    dap_seq_link #(.GAP_CYCLES(GAP_CYCLES)) u_link (
        .clk          (clk),
        .resetn       (resetn),
        .issue        (issue),
        .cmd          (seq_cmd(cmd_t, cmd_cnt)),
        .data         (cmd_data),
        .done         (link_done),
        .busy         (link_busy),
        .seq_tx_valid (seq_tx_valid),
        .seq_tx_cmd   (seq_tx_cmd),
        .seq_tx_data  (seq_tx_data),
        .seq_rx_valid (seq_rx_valid)
    );

endmodule

// File: tb/tb_dap_swd_xfer_ctrl.sv
// Randomised bench for dap_swd_xfer_ctrl: a transfer-level reference model builds
// the expected command script and response; an engine model and a monitor check them.
module tb_dap_swd_xfer_ctrl;
    import dap_swd_pkg::*;

    localparam int          TURN       = 1;
    localparam logic [15:0] RETRY_MAX  = 16'd2;
    localparam int          GAP_CYCLES = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        xfer_req_valid = 1'b0;
    logic        xfer_req_ready;
    logic        xfer_apndp = 1'b0;
    logic        xfer_rnw = 1'b0;
    logic [1:0]  xfer_addr = '0;
    logic [31:0] xfer_wdata = '0;
    logic        xfer_rsp_valid;
    logic [2:0]  xfer_rsp_ack;
    logic [31:0] xfer_rsp_rdata;
    logic        xfer_rsp_perr;
    logic        seq_tx_valid;
    logic [15:0] seq_tx_cmd;
    logic [63:0] seq_tx_data;
    logic        seq_rx_valid = 1'b0;
    logic [15:0] seq_rx_flag = '0;
    logic [63:0] seq_rx_data = '0;

    always #5 clk = ~clk;

    dap_swd_xfer_ctrl #(.TURN(TURN), .RETRY_MAX(RETRY_MAX), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .resetn(resetn),
        .xfer_req_valid(xfer_req_valid), .xfer_req_ready(xfer_req_ready),
        .xfer_apndp(xfer_apndp), .xfer_rnw(xfer_rnw), .xfer_addr(xfer_addr), .xfer_wdata(xfer_wdata),
        .xfer_rsp_valid(xfer_rsp_valid), .xfer_rsp_ack(xfer_rsp_ack),
        .xfer_rsp_rdata(xfer_rsp_rdata), .xfer_rsp_perr(xfer_rsp_perr),
        .seq_tx_valid(seq_tx_valid), .seq_tx_cmd(seq_tx_cmd), .seq_tx_data(seq_tx_data),
        .seq_rx_valid(seq_rx_valid), .seq_rx_flag(seq_rx_flag), .seq_rx_data(seq_rx_data)
    );

    typedef struct packed {
        logic [15:0] cmd;
        logic [63:0] data;
        logic        chk;
        logic [63:0] rx;
        logic [15:0] flag;
        logic        stall;
    } step_t;

    typedef struct packed {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
    } rsp_t;

    typedef struct packed {
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  n_wait;
        logic [2:0]  final_ack;
        logic        flip;
        logic        bad;
        logic [3:0]  bad_idx;
        logic        stall;
        logic [3:0]  stall_idx;
    } scn_t;

    int    checks = 0;
    int    failures = 0;
    step_t script_q[$];
    rsp_t  rsp_q[$];
    rsp_t  last_rsp = '0;
    bit    eng_stalled = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic step_t mk(input logic t, input int cnt, input logic [63:0] d,
                                 input logic chk, input logic [63:0] rx);
        step_t s;
        s.cmd   = {SEQ_CMD_SWD_SEQ, 4'b0000, t, 7'(cnt)};
        s.data  = d;
        s.chk   = chk;
        s.rx    = rx;
        s.flag  = s.cmd;
        s.stall = 1'b0;
        return s;
    endfunction

    function automatic logic [63:0] req_wire(input scn_t s);
        logic [63:0] d = '0;
        d[63] = 1'b1;
        d[62] = s.apndp;
        d[61] = s.rnw;
        d[60] = s.addr[0];
        d[59] = s.addr[1];
        d[58] = s.apndp ^ s.rnw ^ s.addr[0] ^ s.addr[1];
        d[57] = 1'b0;
        d[56] = 1'b1;
        return d;
    endfunction

    function automatic logic [63:0] wdata_wire(input logic [31:0] w);
        logic [63:0] d = '0;
        for (int i = 0; i < 32; i++) d[63-i] = w[i];
        d[31] = ^w;
        return d;
    endfunction

    function automatic logic [63:0] rdata_rx(input logic [31:0] r, input logic flip);
        logic [63:0] d = '0;
        for (int i = 0; i < 32; i++) d[32-i] = r[i];
        d[0] = (^r) ^ flip;
        return d;
    endfunction

    task automatic plan(input scn_t s);
        step_t steps[$];
        step_t tmp;
        rsp_t  r = '0;
        int    retries = 0;
        int    attempt = 0;
        bit    fin = 0;
        logic [2:0] a;
        while (!fin) begin
            a = (attempt < int'(s.n_wait)) ? ACK_WAIT : s.final_ack;
            attempt++;
            steps.push_back(mk(1'b0, 8, req_wire(s), 1'b1, '0));
            steps.push_back(mk(1'b1, TURN + 3, '0, 1'b0, {61'd0, a[0], a[1], a[2]}));
            if (a == ACK_OK) begin
                if (s.rnw) begin
                    steps.push_back(mk(1'b1, 33, '0, 1'b0, rdata_rx(s.rdata, s.flip)));
                    steps.push_back(mk(1'b1, TURN, '0, 1'b0, '0));
                    r.rdata = s.rdata;
                    r.perr  = s.flip;
                end else begin
                    steps.push_back(mk(1'b1, TURN, '0, 1'b0, '0));
                    steps.push_back(mk(1'b0, 33, wdata_wire(s.wdata), 1'b1, '0));
                end
                r.ack = a;
                fin   = 1;
            end else begin
                steps.push_back(mk(1'b1, TURN, '0, 1'b0, '0));
                if (a == ACK_WAIT && retries < int'(RETRY_MAX)) retries++;
                else begin
                    r.ack = a;
                    fin   = 1;
                end
            end
        end
        if (s.bad && int'(s.bad_idx) < steps.size()) begin
            while (steps.size() > int'(s.bad_idx) + 1) void'(steps.pop_back());
            tmp           = steps[s.bad_idx];
            tmp.flag[6:0] = tmp.cmd[6:0] + 7'd1;
            steps[s.bad_idx] = tmp;
            r = '{ack: ACK_PROTO_ERR, rdata: 32'd0, perr: 1'b0};
        end
        if (s.stall && int'(s.stall_idx) < steps.size()) begin
            while (steps.size() > int'(s.stall_idx) + 1) void'(steps.pop_back());
            tmp       = steps[s.stall_idx];
            tmp.stall = 1'b1;
            steps[s.stall_idx] = tmp;
        end else begin
            rsp_q.push_back(r);
        end
        foreach (steps[i]) script_q.push_back(steps[i]);
    endtask

    // ---------------- sequence engine model ----------------
    initial begin
        int    phase = 0;
        int    delay = 0;
        int    hold = 0;
        int    wait_cnt = 0;
        int    low_cnt = 1000;
        step_t cur;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                seq_rx_valid = 1'b0;
                seq_rx_flag  = '0;
                seq_rx_data  = '0;
                phase        = 0;
                low_cnt      = 1000;
                continue;
            end
            if (!seq_tx_valid) low_cnt++;
            case (phase)
                0: if (seq_tx_valid) begin
                    check("cmd_gap_ok", low_cnt >= GAP_CYCLES, 1);
                    low_cnt = 0;
                    if (script_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: got %h expected none", seq_tx_cmd);
                        cur = '{cmd: seq_tx_cmd, data: '0, chk: 1'b0, rx: '0, flag: seq_tx_cmd, stall: 1'b0};
                    end else begin
                        cur = script_q.pop_front();
                        check("seq_tx_cmd", seq_tx_cmd, cur.cmd);
                        if (cur.chk) check("seq_tx_data", seq_tx_data, cur.data);
                    end
                    if (cur.stall) begin
                        eng_stalled = 1;
                        phase = 3;
                    end else begin
                        delay = $urandom_range(0, 4);
                        phase = 1;
                    end
                end
                1: if (delay == 0) begin
                    seq_rx_flag  = cur.flag;
                    seq_rx_data  = cur.rx;
                    seq_rx_valid = 1'b1;
                    wait_cnt     = 0;
                    phase        = 2;
                end else delay--;
                2: begin
                    wait_cnt++;
                    if (!seq_tx_valid || wait_cnt > 200) begin
                        if (seq_tx_valid) begin
                            checks++;
                            failures++;
                            $display("FAIL tx_valid_release: got 1 expected 0");
                        end
                        hold  = $urandom_range(0, 2);
                        phase = 4;
                    end
                end
                4: if (hold == 0) begin
                    seq_rx_valid = 1'b0;
                    seq_rx_data  = 64'($urandom);
                    phase        = 0;
                end else hold--;
                default: ;
            endcase
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (xfer_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got ack %b expected no pulse", xfer_rsp_ack);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_ack", xfer_rsp_ack, r.ack);
                    check("rsp_rdata", xfer_rsp_rdata, r.rdata);
                    check("rsp_perr", xfer_rsp_perr, r.perr);
                    last_rsp = r;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic scn_t mk_scn(input logic apndp, input logic rnw, input logic [1:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    input int n_wait, input logic [2:0] final_ack, input logic flip);
        scn_t s = '0;
        s.apndp = apndp; s.rnw = rnw; s.addr = addr; s.wdata = wdata; s.rdata = rdata;
        s.n_wait = 3'(n_wait); s.final_ack = final_ack; s.flip = flip;
        return s;
    endfunction

    task automatic start_xfer(input scn_t s);
        int t = 0;
        while (!xfer_req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_before_issue", xfer_req_ready, 1);
        check("rsp_ack_held", xfer_rsp_ack, last_rsp.ack);
        check("rsp_rdata_held", xfer_rsp_rdata, last_rsp.rdata);
        plan(s);
        xfer_apndp     = s.apndp;
        xfer_rnw       = s.rnw;
        xfer_addr      = s.addr;
        xfer_wdata     = s.wdata;
        xfer_req_valid = 1'b1;
        @(negedge clk);
        xfer_req_valid = 1'b0;
    endtask

    task automatic run_xfer(input scn_t s);
        int t = 0;
        start_xfer(s);
        while (rsp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
            if (!xfer_req_ready && $urandom_range(0, 7) == 0) begin
                xfer_req_valid = 1'b1;
                xfer_apndp     = 1'($urandom);
                xfer_rnw       = 1'($urandom);
                xfer_addr      = 2'($urandom);
                xfer_wdata     = $urandom;
            end else begin
                xfer_req_valid = 1'b0;
            end
        end
        xfer_req_valid = 1'b0;
        check("rsp_pending_after_wait", rsp_q.size(), 0);
        check("script_drained", script_q.size(), 0);
        rsp_q.delete();
        script_q.delete();
    endtask

    initial begin
        scn_t s;
        int   t;
        repeat (3) @(negedge clk);
        check("reset_req_ready", xfer_req_ready, 1);
        check("reset_tx_valid", seq_tx_valid, 0);
        check("reset_tx_cmd", seq_tx_cmd, 0);
        check("reset_tx_data", seq_tx_data, 0);
        check("reset_rsp_valid", xfer_rsp_valid, 0);
        check("reset_rsp_ack", xfer_rsp_ack, 0);
        check("reset_rsp_rdata", xfer_rsp_rdata, 0);
        check("reset_rsp_perr", xfer_rsp_perr, 0);
        resetn = 1'b1;
        @(negedge clk);

        // DPIDR read, AP write, WAIT retries, retry exhaustion, FAULT, protocol error, bad parity
        run_xfer(mk_scn(1'b0, 1'b1, 2'b00, 32'h0, 32'h2BA01477, 0, ACK_OK, 1'b0));
        run_xfer(mk_scn(1'b1, 1'b0, 2'b01, 32'h23000052, 32'h0, 0, ACK_OK, 1'b0));
        run_xfer(mk_scn(1'b1, 1'b1, 2'b11, 32'h0, 32'hCAFEF00D, 2, ACK_OK, 1'b0));
        run_xfer(mk_scn(1'b0, 1'b0, 2'b10, 32'h12345678, 32'h0, 3, ACK_OK, 1'b0));
        run_xfer(mk_scn(1'b1, 1'b1, 2'b01, 32'h0, 32'h5A5A5A5A, 0, ACK_FAULT, 1'b0));
        run_xfer(mk_scn(1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 0, 3'b000, 1'b0));
        run_xfer(mk_scn(1'b1, 1'b1, 2'b10, 32'h0, 32'h80000001, 0, ACK_OK, 1'b1));

        // Flag count mismatch on the ACK command and on the read-data command
        s = mk_scn(1'b1, 1'b1, 2'b00, 32'h0, 32'h11112222, 0, ACK_OK, 1'b0);
        s.bad = 1'b1; s.bad_idx = 4'd1;
        run_xfer(s);
        s.bad_idx = 4'd2;
        run_xfer(s);

        // Reset while the read-data command is outstanding
        s = mk_scn(1'b1, 1'b1, 2'b11, 32'h0, 32'hDEADBEEF, 0, ACK_OK, 1'b0);
        s.stall = 1'b1; s.stall_idx = 4'd2;
        start_xfer(s);
        t = 0;
        while (!eng_stalled && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reached_rdata_stall", eng_stalled, 1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", seq_tx_valid, 0);
        check("abort_rsp_valid", xfer_rsp_valid, 0);
        check("abort_req_ready", xfer_req_ready, 1);
        check("abort_rsp_ack", xfer_rsp_ack, 0);
        @(negedge clk);
        script_q.delete();
        eng_stalled = 0;
        last_rsp    = '0;
        resetn      = 1'b1;
        @(negedge clk);
        run_xfer(mk_scn(1'b0, 1'b1, 2'b00, 32'h0, 32'h2BA01477, 0, ACK_OK, 1'b0));

        // Randomised transfers
        for (int n = 0; n < 40; n++) begin
            int pick;
            s = mk_scn(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                       $urandom_range(0, 3), ACK_OK, ($urandom_range(0, 5) == 0));
            pick = $urandom_range(0, 9);
            if (pick == 6) s.final_ack = ACK_FAULT;
            else if (pick == 7) s.final_ack = ACK_WAIT;
            else if (pick == 8) s.final_ack = 3'b000;
            else if (pick == 9) s.final_ack = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                s.bad     = 1'b1;
                s.bad_idx = 4'($urandom_range(0, 5));
            end
            run_xfer(s);
        end

        repeat (20) @(negedge clk);
        check("final_script_empty", script_q.size(), 0);
        check("final_rsp_empty", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
